mem_stage_stbuf: RTL and testbench
==================================

Name: mem_stage_stbuf

Overview:
- Parametrised memory-stage front end.
- Sits between the pipeline MEM stage (ALU address, rs2 data, byte mask, write enable) and a data memory with a ready/valid handshake.
- Buffers stores in a DEPTH-entry FIFO so they retire without stalling.
- Serves loads by forwarding from the buffer or by a memory read, and drains the buffer on a fence.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; must equal 32 (4 byte lanes).
- DEPTH, 4, store-buffer entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  MEM-stage request present.
- i_wren  in  1  1 = store, 0 = load.
- i_bmask  in  4  byte-lane enables (lane k = bits 8k+7:8k).
- i_addr  in  ADDR_W  byte address; bits 1:0 ignored (word-aligned).
- i_wdata  in  DATA_W  store data, already lane-aligned.
- i_fence  in  1  drain request; held by the pipeline until o_stall is low.
- o_stall  out  1  current request/fence not accepted; pipeline holds inputs.
- o_rdata  out  DATA_W  load result word.
- o_rdata_valid  out  1  one-cycle pulse with o_rdata.
- o_mem_req  out  1  memory request valid.
- o_mem_we  out  1  memory write.
- o_mem_addr  out  ADDR_W  word-aligned address (bits 1:0 = 0).
- o_mem_wdata  out  DATA_W  write data.
- o_mem_bmask  out  4  write byte enables.
- i_mem_ready  in  1  memory accepts request this cycle.
- i_mem_rdata  in  DATA_W  read data.
- i_mem_rvalid  in  1  read data valid (≥1 cycle after accept).
- o_sb_count  out  CNT_W  buffer occupancy.

Behaviour:
- Reset values: buffer empty, o_sb_count=0, FSM=IDLE, o_rdata=0, o_rdata_valid=0, o_mem_req=0, o_mem_we=0, o_mem_addr/wdata/bmask=0.
- Reset mid-operation: buffered stores are discarded, any outstanding read is abandonned, and a later i_mem_rvalid is ignored.
- Acceptance rule: a request is accepted when i_req_valid=1 and o_stall=0. o_stall is combinational from inputs and state.
- Store:
  - Accepted when count<DEPTH and FSM=IDLE; enqueued at tail on that edge.
  - Full: stall, even if a pop occurs the same cycle (no full-pop bypass).
- Load match rule: an entry matches when its word address equals i_addr[ADDR_W-1:2]. The youngest matching entry is the one used.
- Load, full hit (youngest match covers all of i_bmask):
  - Accepted in IDLE with no stall.
  - Next cycle: o_rdata = entry data, o_rdata_valid = 1.
- Load, partial hit (some match exists, not fully covered): stall until no matching entry remains; then treated as a miss.
- Load, miss: stall. Go IDLE -> LD_REQ.
  - LD_REQ: o_mem_req=1, o_mem_we=0; on i_mem_ready -> LD_WAIT.
  - LD_WAIT: on i_mem_rvalid, capture o_rdata = i_mem_rdata, pulse o_rdata_valid, go to IDLE, and drop stall that same cycle (load retires).
- Drain:
  - In IDLE with the buffer non-empty and no miss load issuing this cycle, present the head entry: o_mem_req=1, o_mem_we=1, addr/data/bmask from head.
  - Pop on i_mem_ready.
  - A miss load wins arbitration, but only after its partial-hit condition has cleared.
- Simultaneous push and pop: count unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- Fence:
  - i_fence=1 stalls until count=0 and FSM=IDLE (state FENCE while draining).
  - Accepted the cycle count reaches 0. i_req_valid is ignored during a fence.
- o_mem_* outputs are combinational from state/head; they must hold stable while o_mem_req=1 and i_mem_ready=0.

Test Plan:
- Reset, then 3 stores (0x100 mask F data 0x11111111; 0x104 mask 3 data 0x2222; 0x108 mask F data 0x33333333) with i_mem_ready=0 -> no stall, o_sb_count=3. Then ready=1 -> three writes in FIFO order, count returns to 0.
- DEPTH=4, ready=0, 5 stores -> 5th stalls with count=4. Ready=1 for one cycle -> pop, 5th accepted next cycle, count=4.
- Store 0x200 mask F 0xDEADBEEF (ready=0), then load 0x200 mask 3 -> no stall; next cycle o_rdata=0xDEADBEEF, o_rdata_valid=1, no memory read issued.
- Store 0x300 mask 1 (ready=0), then load 0x300 mask F -> stall. Set ready=1 -> store drains, read issued; rvalid with 0xCAFEF00D two cycles later -> o_rdata=0xCAFEF00D, stall drops.
- 2 buffered stores, i_fence=1 -> stall until both writes are accepted; fence accepted in the cycle count=0.
- Assert i_reset=0 during LD_WAIT with 2 buffered stores -> count=0, o_mem_req=0, o_rdata_valid=0; a later i_mem_rvalid produces no o_rdata_valid.

Source files
------------

// File: rtl/mem_stage_stbuf.sv
// ---------------------------------------------------------------------------
// mem_stage_stbuf
//
// Memory-stage front end with a store buffer. Stores from the MEM stage are
// queued in a DEPTH-entry FIFO and retire without waiting for memory. Loads
// are served by forwarding from the youngest matching buffered store, or by a
// memory read when no entry matches. A fence stalls until the buffer has
// drained.
//
// Ports:
//   i_clk, i_reset      clock (rising edge), asynchronous active-low reset
//   i_req_valid         MEM-stage request present
//   i_wren              1 = store, 0 = load
//   i_bmask             byte-lane enables (lane k = bits 8k+7:8k)
//   i_addr              byte address, bits 1:0 ignored
//   i_wdata             lane-aligned store data
//   i_fence             drain request, held until o_stall is low
//   o_stall             current request/fence not accepted
//   o_rdata             load result word (registered)
//   o_rdata_valid       one-cycle pulse with o_rdata
//   o_mem_req/we/addr/wdata/bmask
//                       memory request, held stable until i_mem_ready
//   i_mem_ready         memory accepts the request this cycle
//   i_mem_rdata         read data
//   i_mem_rvalid        read data valid
//   o_sb_count          store-buffer occupancy
// ---------------------------------------------------------------------------
module mem_stage_stbuf #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    input  logic              i_wren,
    input  logic [3:0]        i_bmask,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_fence,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rdata_valid,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_rvalid,
    output logic [CNT_W-1:0]  o_sb_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned WA_W  = ADDR_W - 2;

    typedef enum logic [1:0] {
        StIdle,
        StLdReq,
        StLdWait,
        StFence
    } state_e;

    // Buffer storage (word address, data, byte mask per entry)
    logic [WA_W-1:0]   r_sb_addr [DEPTH];
    logic [DATA_W-1:0] r_sb_data [DEPTH];
    logic [3:0]        r_sb_mask [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    state_e            r_state;
    logic [WA_W-1:0]   r_ld_addr;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdata_valid;
    // Set while a drain write is on the bus but not yet accepted; the bus
    // must not change under it, so a miss load waits for it to complete.
    logic              r_drain_hold;

    logic [WA_W-1:0]   w_req_waddr;
    logic              w_any_match;
    logic [DATA_W-1:0] w_hit_data;
    logic [3:0]        w_hit_mask;
    logic              w_full_hit;
    logic              w_is_idle;
    logic              w_req_ld;
    logic              w_req_st;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_ld_hit;
    logic              w_miss_go;
    logic              w_drain;
    logic              w_ld_done;
    logic              w_fence_done;
    logic              w_unused_addr;

    assign w_req_waddr   = i_addr[ADDR_W-1:2];
    assign w_unused_addr = ^i_addr[1:0];

    // Walk entries oldest to youngest so the youngest match overrides.
    always_comb begin
        w_any_match = 1'b0;
        w_hit_data  = '0;
        w_hit_mask  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if ((CNT_W'(i) < r_count) &&
                (r_sb_addr[r_head + PTR_W'(i)] == w_req_waddr)) begin
                w_any_match = 1'b1;
                w_hit_data  = r_sb_data[r_head + PTR_W'(i)];
                w_hit_mask  = r_sb_mask[r_head + PTR_W'(i)];
            end
        end
    end

    assign w_full_hit   = w_any_match && ((w_hit_mask & i_bmask) == i_bmask);
    assign w_is_idle    = (r_state == StIdle);
    assign w_req_ld     = i_req_valid && !i_wren && !i_fence;
    assign w_req_st     = i_req_valid && i_wren && !i_fence;
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_push       = w_is_idle && w_req_st && !w_full;
    assign w_ld_hit     = w_is_idle && w_req_ld && w_full_hit;
    // Any match at all (partial included) keeps the load off the bus until
    // the overlapping stores have drained.
    assign w_miss_go    = w_is_idle && w_req_ld && !w_any_match && !r_drain_hold;
    assign w_drain      = (r_count != '0) &&
                          ((w_is_idle && !w_miss_go) || (r_state == StFence));
    assign w_pop        = w_drain && i_mem_ready;
    assign w_ld_done    = (r_state == StLdWait) && i_mem_rvalid;
    assign w_fence_done = (r_count == '0) && (w_is_idle || (r_state == StFence));

    always_comb begin
        o_stall = 1'b0;
        if (i_fence) begin
            o_stall = !w_fence_done;
        end else if (i_req_valid) begin
            if (i_wren) begin
                o_stall = !w_push;
            end else begin
                o_stall = !(w_ld_hit || w_ld_done);
            end
        end
    end

    // Memory request mux: a pending read owns the bus, otherwise the head
    // store is presented.
    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        if (r_state == StLdReq) begin
            o_mem_req  = 1'b1;
            o_mem_addr = {r_ld_addr, 2'b00};
        end else if (w_drain) begin
            o_mem_req   = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = {r_sb_addr[r_head], 2'b00};
            o_mem_wdata = r_sb_data[r_head];
            o_mem_bmask = r_sb_mask[r_head];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_sb_addr[r_tail] <= w_req_waddr;
            r_sb_data[r_tail] <= i_wdata;
            r_sb_mask[r_tail] <= i_bmask;
        end
    end

    // Control FSM with registered load result
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= StIdle;
            r_ld_addr     <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_drain_hold  <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_drain_hold  <= w_drain && !i_mem_ready;
            unique case (r_state)
                StIdle: begin
                    if (i_fence) begin
                        if (r_count != '0) begin
                            r_state <= StFence;
                        end
                    end else if (w_ld_hit) begin
                        r_rdata       <= w_hit_data;
                        r_rdata_valid <= 1'b1;
                    end else if (w_miss_go) begin
                        r_ld_addr <= w_req_waddr;
                        r_state   <= StLdReq;
                    end
                end
                StLdReq: begin
                    if (i_mem_ready) begin
                        r_state <= StLdWait;
                    end
                end
                StLdWait: begin
                    if (i_mem_rvalid) begin
                        r_rdata       <= i_mem_rdata;
                        r_rdata_valid <= 1'b1;
                        r_state       <= StIdle;
                    end
                end
                StFence: begin
                    if ((r_count == '0) || !i_fence) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_sb_count    = r_count;

endmodule

// File: tb/tb_mem_stage_stbuf.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_stbuf
//
// Cycle-by-cycle directed vectors for mem_stage_stbuf (DEPTH = 4). Inputs are
// applied on the falling edge and outputs sampled 1 time unit later, so the
// registered outputs reflect the state left by the previous rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage_stbuf;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        wren;
    logic [3:0]  bmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fence;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [2:0]  sb_count;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_stbuf dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_req_valid   (req_valid),
        .i_wren        (wren),
        .i_bmask       (bmask),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .i_fence       (fence),
        .o_stall       (stall),
        .o_rdata       (rdata),
        .o_rdata_valid (rdata_valid),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_mem_bmask   (mem_bmask),
        .i_mem_ready   (mem_ready),
        .i_mem_rdata   (mem_rdata),
        .i_mem_rvalid  (mem_rvalid),
        .o_sb_count    (sb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic        we;
        logic [3:0]  bm;
        logic [31:0] ad;
        logic [31:0] wd;
        logic        fe;
        logic        rdy;
        logic        rvl;
        logic [31:0] rd;
        logic        e_st;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_ad;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
        logic        e_vld;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rv, input logic we, input logic [3:0] bm,
                       input logic [31:0] ad, input logic [31:0] wd, input logic fe,
                       input logic rdy, input logic rvl, input logic [31:0] rd,
                       input logic e_st, input logic e_req, input logic e_we,
                       input logic [31:0] e_ad, input logic [31:0] e_wd,
                       input logic [2:0] e_cnt, input logic e_vld, input logic [31:0] e_rd);
        vec_t v;
        v.rv = rv;     v.we = we;       v.bm = bm;     v.ad = ad;       v.wd = wd;
        v.fe = fe;     v.rdy = rdy;     v.rvl = rvl;   v.rd = rd;
        v.e_st = e_st; v.e_req = e_req; v.e_we = e_we; v.e_ad = e_ad;   v.e_wd = e_wd;
        v.e_cnt = e_cnt; v.e_vld = e_vld; v.e_rd = e_rd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic we, input logic [3:0] bm,
                         input logic [31:0] ad, input logic [31:0] wd, input logic fe,
                         input logic rdy, input logic rvl, input logic [31:0] rd);
        req_valid  = rv;
        wren       = we;
        bmask      = bm;
        addr       = ad;
        wdata      = wd;
        fence      = fe;
        mem_ready  = rdy;
        mem_rvalid = rvl;
        mem_rdata  = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);

        // Store ordering and drain (ready low, then high)
        add(1,1,4'hF,32'h100,32'h11111111,0,0,0,0, 0,0,0,32'h0,32'h0,3'd0,0,0);
        add(1,1,4'h3,32'h104,32'h00002222,0,0,0,0, 0,1,1,32'h100,32'h11111111,3'd1,0,0);
        add(1,1,4'hF,32'h108,32'h33333333,0,0,0,0, 0,1,1,32'h100,32'h11111111,3'd2,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,1,0,0,          0,1,1,32'h100,32'h11111111,3'd3,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,1,0,0,          0,1,1,32'h104,32'h00002222,3'd2,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,1,0,0,          0,1,1,32'h108,32'h33333333,3'd1,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,0,0,0,          0,0,0,32'h0,32'h0,3'd0,0,0);
        // Full buffer: fifth store stalls, also across the popping cycle
        add(1,1,4'hF,32'h10,32'hA0,0,0,0,0, 0,0,0,32'h0,32'h0,3'd0,0,0);
        add(1,1,4'hF,32'h14,32'hA1,0,0,0,0, 0,1,1,32'h10,32'hA0,3'd1,0,0);
        add(1,1,4'hF,32'h18,32'hA2,0,0,0,0, 0,1,1,32'h10,32'hA0,3'd2,0,0);
        add(1,1,4'hF,32'h1C,32'hA3,0,0,0,0, 0,1,1,32'h10,32'hA0,3'd3,0,0);
        add(1,1,4'hF,32'h20,32'hA4,0,0,0,0, 1,1,1,32'h10,32'hA0,3'd4,0,0);
        add(1,1,4'hF,32'h20,32'hA4,0,1,0,0, 1,1,1,32'h10,32'hA0,3'd4,0,0);
        add(1,1,4'hF,32'h20,32'hA4,0,0,0,0, 0,1,1,32'h14,32'hA1,3'd3,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,0,0,0,   0,1,1,32'h14,32'hA1,3'd4,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,1,0,0,   0,1,1,32'h14,32'hA1,3'd4,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,1,0,0,   0,1,1,32'h18,32'hA2,3'd3,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,1,0,0,   0,1,1,32'h1C,32'hA3,3'd2,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,1,0,0,   0,1,1,32'h20,32'hA4,3'd1,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,0,0,0,   0,0,0,32'h0,32'h0,3'd0,0,0);
        // Full forwarding hit (offset byte address, subset mask)
        add(1,1,4'hF,32'h200,32'hDEADBEEF,0,0,0,0, 0,0,0,32'h0,32'h0,3'd0,0,0);
        add(1,0,4'h3,32'h202,32'h0,0,0,0,0,        0,1,1,32'h200,32'hDEADBEEF,3'd1,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,0,0,0,          0,1,1,32'h200,32'hDEADBEEF,3'd1,1,32'hDEADBEEF);
        add(0,0,4'h0,32'h0,32'h0,0,1,0,0,          0,1,1,32'h200,32'hDEADBEEF,3'd1,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,0,0,0,          0,0,0,32'h0,32'h0,3'd0,0,0);
        // Partial hit: drain first, then memory read
        add(1,1,4'h1,32'h300,32'hAA,0,0,0,0,     0,0,0,32'h0,32'h0,3'd0,0,0);
        add(1,0,4'hF,32'h300,32'h0,0,0,0,0,      1,1,1,32'h300,32'hAA,3'd1,0,0);
        add(1,0,4'hF,32'h300,32'h0,0,1,0,0,      1,1,1,32'h300,32'hAA,3'd1,0,0);
        add(1,0,4'hF,32'h300,32'h0,0,1,0,0,      1,0,0,32'h0,32'h0,3'd0,0,0);
        add(1,0,4'hF,32'h300,32'h0,0,1,0,0,      1,1,0,32'h300,32'h0,3'd0,0,0);
        add(1,0,4'hF,32'h300,32'h0,0,0,0,0,      1,0,0,32'h0,32'h0,3'd0,0,0);
        add(1,0,4'hF,32'h300,32'h0,0,0,1,32'hCAFEF00D, 0,0,0,32'h0,32'h0,3'd0,0,0);
        add(0,0,4'h0,32'h0,32'h0,0,0,0,0,        0,0,0,32'h0,32'h0,3'd0,1,32'hCAFEF00D);

        // Reset values
        @(negedge clk);
        #1;
        chk("reset_count", -1, 32'(sb_count), 32'd0);
        chk("reset_rvalid", -1, 32'(rdata_valid), 32'd0);
        chk("reset_rdata", -1, rdata, 32'd0);
        chk("reset_mem_req", -1, 32'(mem_req), 32'd0);
        chk("reset_mem_we", -1, 32'(mem_we), 32'd0);
        chk("reset_mem_addr", -1, mem_addr, 32'd0);
        chk("reset_mem_wdata", -1, mem_wdata, 32'd0);
        chk("reset_mem_bmask", -1, 32'(mem_bmask), 32'd0);
        chk("reset_stall", -1, 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].rv, vecs[k].we, vecs[k].bm, vecs[k].ad, vecs[k].wd,
                  vecs[k].fe, vecs[k].rdy, vecs[k].rvl, vecs[k].rd);
            #1;
            chk("stall", k, 32'(stall), 32'(vecs[k].e_st));
            chk("mem_req", k, 32'(mem_req), 32'(vecs[k].e_req));
            if (vecs[k].e_req) begin
                chk("mem_we", k, 32'(mem_we), 32'(vecs[k].e_we));
                chk("mem_addr", k, mem_addr, vecs[k].e_ad);
                if (vecs[k].e_we) begin
                    chk("mem_wdata", k, mem_wdata, vecs[k].e_wd);
                end
            end
            chk("sb_count", k, 32'(sb_count), 32'(vecs[k].e_cnt));
            chk("rdata_valid", k, 32'(rdata_valid), 32'(vecs[k].e_vld));
            if (vecs[k].e_vld) begin
                chk("rdata", k, rdata, vecs[k].e_rd);
            end
        end

        // Fence: stalls while two stores drain, accepted when count is 0
        @(negedge clk); drive(1, 1, 4'hF, 32'h400, 32'h44, 0, 0, 0, 32'h0);
        #1; chk("fence_st0_stall", 0, 32'(stall), 32'd0);
        @(negedge clk); drive(1, 1, 4'hF, 32'h404, 32'h55, 0, 0, 0, 32'h0);
        #1; chk("fence_st1_stall", 1, 32'(stall), 32'd0);
        @(negedge clk); drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
        #1; chk("fence_stall", 2, 32'(stall), 32'd1);
        chk("fence_count", 2, 32'(sb_count), 32'd2);
        @(negedge clk); drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 0, 32'h0);
        #1; chk("fence_stall", 3, 32'(stall), 32'd1);
        chk("fence_mem_addr", 3, mem_addr, 32'h400);
        chk("fence_mem_we", 3, 32'(mem_we), 32'd1);
        @(negedge clk);
        #1; chk("fence_stall", 4, 32'(stall), 32'd1);
        chk("fence_count", 4, 32'(sb_count), 32'd1);
        chk("fence_mem_wdata", 4, mem_wdata, 32'h55);
        @(negedge clk);
        #1; chk("fence_stall", 5, 32'(stall), 32'd0);
        chk("fence_count", 5, 32'(sb_count), 32'd0);
        chk("fence_mem_req", 5, 32'(mem_req), 32'd0);
        @(negedge clk); drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        #1; chk("post_fence_stall", 6, 32'(stall), 32'd0);

        // Reset while a read is outstanding with two stores buffered
        @(negedge clk); drive(1, 1, 4'hF, 32'h500, 32'h1, 0, 0, 0, 32'h0);
        @(negedge clk); drive(1, 1, 4'hF, 32'h504, 32'h2, 0, 0, 0, 32'h0);
        @(negedge clk); drive(1, 1, 4'hF, 32'h508, 32'h3, 0, 0, 0, 32'h0);
        @(negedge clk); drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0, 32'h0);
        #1; chk("rst_pre_count", 0, 32'(sb_count), 32'd3);
        @(negedge clk); drive(1, 0, 4'hF, 32'h600, 32'h0, 0, 0, 0, 32'h0);
        #1; chk("rst_miss_stall", 1, 32'(stall), 32'd1);
        chk("rst_miss_mem_req", 1, 32'(mem_req), 32'd0);
        @(negedge clk); mem_ready = 1'b1;
        #1; chk("rst_ldreq_req", 2, 32'(mem_req), 32'd1);
        chk("rst_ldreq_we", 2, 32'(mem_we), 32'd0);
        chk("rst_ldreq_addr", 2, mem_addr, 32'h600);
        @(negedge clk); mem_ready = 1'b0;
        #1; chk("rst_ldwait_count", 3, 32'(sb_count), 32'd2);
        chk("rst_ldwait_stall", 3, 32'(stall), 32'd1);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1; chk("rst_count", 4, 32'(sb_count), 32'd0);
        chk("rst_mem_req", 4, 32'(mem_req), 32'd0);
        chk("rst_rvalid", 4, 32'(rdata_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 32'h12345678);
        @(negedge clk); mem_rvalid = 1'b0;
        #1; chk("stale_rvalid", 5, 32'(rdata_valid), 32'd0);
        chk("stale_count", 5, 32'(sb_count), 32'd0);
        @(negedge clk);
        #1; chk("stale_rvalid", 6, 32'(rdata_valid), 32'd0);
        chk("stale_mem_req", 6, 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
